// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, buffers {pc, instr} pairs and hands them to decode over valid/ready.
// Optional FETCH_STATS_EN macro adds fetch_cnt / stall_cnt performance counters.
module instr_fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  input  logic            if_ready,
  output logic            misalign_err
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     stall_cnt
`endif
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0]  fpc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  entry_t           entries [BUF_DEPTH];

  logic pop;
  logic push;
  logic wr_en;

  assign imem_addr = fpc;
  assign if_valid  = (count != '0);

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    if_pc    = '0;
    if_instr = '0;
    if (if_valid) begin
      if_pc    = entries[rd_ptr].pc;
      if_instr = entries[rd_ptr].instr;
    end
  end

  // A full buffer still accepts a new word when the head leaves in the same cycle.
  always_comb begin
    pop   = if_valid & if_ready;
    push  = (count < DEPTH_C) | pop;
    wr_en = push & ~redirect_valid;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fpc          <= RESET_PC;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      misalign_err <= 1'b0;
    end else if (redirect_valid) begin
      // Redirect outranks everything: flush, drop any handshake, reload aligned PC.
      fpc          <= {redirect_target[XLEN-1:2], 2'b00};
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      misalign_err <= (redirect_target[1:0] != 2'b00);
    end else begin
      misalign_err <= 1'b0;
      count        <= count_nxt;
      if (push) begin
        fpc    <= fpc + XLEN'(4);
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // NOTE: buffer storage has no reset; outputs are gated by count, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      entries[wr_ptr] <= '{pc: fpc, instr: imem_rdata};
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (wr_en) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (if_valid && !if_ready) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus $urandom traffic against a queue-based model.
// Define FETCH_STATS_EN here as in the RTL build to also check the statistics counters.
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        reset_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        misalign_err;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  instr_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .if_ready        (if_ready),
    .misalign_err    (misalign_err)
`ifdef FETCH_STATS_EN
    ,
    .fetch_cnt       (fetch_cnt),
    .stall_cnt       (stall_cnt)
`endif
  );

  // Instruction memory: combinational read, contents derived from the address.
  assign imem_rdata = 32'hA000_0000 | imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: fetch PC, a queue of fetched PCs, pending error pulse, stats.
  logic [31:0] m_fpc;
  logic [31:0] m_q[$];
  logic        m_mis;
  logic [31:0] m_fetches;
  logic [31:0] m_stalls;

  task automatic model_reset();
    m_fpc     = RESET_PC;
    m_q.delete();
    m_mis     = 1'b0;
    m_fetches = '0;
    m_stalls  = '0;
  endtask

  task automatic compare_outputs();
    logic [31:0] head;
    head = (m_q.size() != 0) ? m_q[0] : 32'h0;
    check("imem_addr", imem_addr, m_fpc);
    check("if_valid", {31'b0, if_valid}, {31'b0, m_q.size() != 0});
    check("if_pc", if_pc, head);
    check("if_instr", if_instr, (m_q.size() != 0) ? (32'hA000_0000 | head) : 32'h0);
    check("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
`ifdef FETCH_STATS_EN
    check("fetch_cnt", fetch_cnt, m_fetches);
    check("stall_cnt", stall_cnt, m_stalls);
`endif
  endtask

  // One clock: drive inputs, compare at negedge, advance model at posedge.
  task automatic cycle(input logic rv, input logic [31:0] tgt, input logic rdy);
    bit pop;
    bit push;
    redirect_valid  = rv;
    redirect_target = tgt;
    if_ready        = rdy;
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    if (m_q.size() != 0 && !rdy) m_stalls++;
    if (rv) begin
      m_q.delete();
      m_fpc = {tgt[31:2], 2'b00};
      m_mis = (tgt[1:0] != 2'b00);
    end else begin
      m_mis = 1'b0;
      pop   = (m_q.size() != 0) && rdy;
      push  = (m_q.size() < DEPTH) || pop;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back(m_fpc);
        m_fpc = m_fpc + 32'd4;
        m_fetches++;
      end
    end
    #1;
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_if_valid", {31'b0, if_valid}, 32'h0);
    check("rst_imem_addr", imem_addr, RESET_PC);
    check("rst_if_pc", if_pc, 32'h0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n         = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    if_ready        = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    compare_outputs();
    reset_n = 1'b1;

    // Streaming from reset, then back-pressure and release.
    repeat (4) cycle(1'b0, '0, 1'b1);
    repeat (5) cycle(1'b0, '0, 1'b0);
    repeat (4) cycle(1'b0, '0, 1'b1);

    // Redirect while full, misaligned redirect, wrap across the top of the address space.
    repeat (3) cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 32'h100, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 32'h102, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (4) cycle(1'b0, '0, 1'b1);

    // Back-to-back redirects: the last one wins.
    cycle(1'b1, 32'h200, 1'b1);
    cycle(1'b1, 32'h301, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b1);

    // Random traffic with a mid-stream asynchronous reset.
    for (int i = 0; i < 400; i++) begin
      logic        rv;
      logic [31:0] tgt;
      rv  = ($urandom_range(0, 9) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      cycle(rv, tgt, ($urandom_range(0, 9) < 7));
      if (i == 200) mid_reset();
    end
    mid_reset();
    repeat (4) cycle(1'b0, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
